// File: rtl/fetch_pc_redirect_if.sv
// Fetch PC generator bus: predictor/EX control in, fetch PC and slot state out.
// Optional performance counters present when PERF_COUNTERS_EN is defined.
interface fetch_pc_redirect_if #(
  parameter int DEPTH = 3
);
  logic              stall;
  logic              pred_hit;
  logic [31:0]       pred_pc;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic [31:0]       PC_in;
  logic              fetch_valid;
  logic [DEPTH-1:0]  slot_valid;
  logic              flush;
`ifdef PERF_COUNTERS_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       redirect_cnt;

  modport master (
    output stall, pred_hit, pred_pc, mispredict, redirect_pc,
    input  PC_in, fetch_valid, slot_valid, flush, fetch_cnt, redirect_cnt
  );
  modport slave (
    input  stall, pred_hit, pred_pc, mispredict, redirect_pc,
    output PC_in, fetch_valid, slot_valid, flush, fetch_cnt, redirect_cnt
  );
`else
  modport master (
    output stall, pred_hit, pred_pc, mispredict, redirect_pc,
    input  PC_in, fetch_valid, slot_valid, flush
  );
  modport slave (
    input  stall, pred_hit, pred_pc, mispredict, redirect_pc,
    output PC_in, fetch_valid, slot_valid, flush
  );
`endif
endinterface

// File: rtl/fetch_pc_redirect.sv
// Fetch-stage PC generator upstream of the branch predictor.
// Next PC: mispredict redirect > stall hold > predictor target > PC+4.
// vld_pipe tracks in-flight fetch slots ([0]=IF .. [DEPTH-1]=EX); a redirect
// squashes the youngest FLUSH_SLOTS slots and pulses flush for one cycle.
// Optional: PERF_COUNTERS_EN adds saturating fetch/redirect counters.
// DEPTH range 2..8, 1 <= FLUSH_SLOTS <= DEPTH.
module fetch_pc_redirect #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH       = 3,
  parameter int          FLUSH_SLOTS = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_pc_redirect_if.slave bus
);
  localparam int STAGES = DEPTH - 1;
  localparam int unsigned LOW_BITS = (1 << FLUSH_SLOTS) - 1;
  localparam logic [STAGES:0] KEEP_MASK = ~DEPTH'(LOW_BITS);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t          state;
  logic [31:0]     pc_q;
  logic            fv_q;
  logic            flush_q;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] vld_shift;

  // Age every slot by one; the current fetch enters at IF.
  assign vld_shift = {vld_pipe[STAGES-1:0], fv_q};

  // PC / slot / state sequencing; REDIRECT steers exactly like RUN and only
  // differs in returning to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      fv_q     <= 1'b0;
      flush_q  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          fv_q     <= 1'b1;
          vld_pipe <= vld_shift;
        end
        default: begin
          if (bus.mispredict) begin
            // stall is ignored: the redirect always wins
            state    <= REDIRECT;
            pc_q     <= {bus.redirect_pc[31:2], 2'b00};
            flush_q  <= 1'b1;
            vld_pipe <= vld_shift & KEEP_MASK;
          end else begin
            state <= RUN;
            if (!bus.stall) begin
              pc_q     <= bus.pred_hit ? bus.pred_pc : pc_q + 32'd4;
              vld_pipe <= vld_shift;
            end
          end
        end
      endcase
    end
  end

  assign bus.PC_in       = pc_q;
  assign bus.fetch_valid = fv_q;
  assign bus.slot_valid  = vld_pipe;
  assign bus.flush       = flush_q;

`ifdef PERF_COUNTERS_EN
  logic [31:0] fcnt_q;
  logic [31:0] rcnt_q;

  // Saturating counts of live non-stalled fetches and accepted redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      if (fv_q && !bus.stall && fcnt_q != 32'hFFFF_FFFF) fcnt_q <= fcnt_q + 32'd1;
      if (fv_q && bus.mispredict && rcnt_q != 32'hFFFF_FFFF) rcnt_q <= rcnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt    = fcnt_q;
  assign bus.redirect_cnt = rcnt_q;
`endif
endmodule
